// File: rtl/neuron_cfg_loader.sv
// Serial configuration sequencer for the neuron array: steers a valid/ready word stream into
// per-neuron Vmem, mu, neuronI and one Q-RAM row, with one-cycle registered write strobes.
module neuron_cfg_loader #(
    parameter int FP_DATA_WIDTH   = 16,
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int NUM_NEURON      = 4,
    parameter int NEURON_ID_WIDTH = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic                       in_valid_i,
    input  logic [FP_DATA_WIDTH-1:0]   in_data_i,
    output logic                       in_ready_o,
    output logic                       wr_en_o,
    output logic [NEURON_ID_WIDTH-1:0] wr_neuron_o,
    output logic [1:0]                 wr_field_o,
    output logic [NEURON_ID_WIDTH-1:0] wr_qaddr_o,
    output logic [FP_DATA_WIDTH-1:0]   wr_data_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_id_o,
    output logic                       err_q_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_QROW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [NEURON_ID_WIDTH-1:0] LAST_IDX = NEURON_ID_WIDTH'(NUM_NEURON - 1);
    localparam logic [1:0]                 FLD_NID  = 2'd2;
    localparam logic [1:0]                 FLD_Q    = 2'd3;

    state_t                     state_q, state_d;
    logic [NEURON_ID_WIDTH-1:0] neuron_q, neuron_d;
    logic [1:0]                 fld_q, fld_d;
    logic [NEURON_ID_WIDTH-1:0] qaddr_q, qaddr_d;

    logic                       wr_en_q, wr_en_d;
    logic [NEURON_ID_WIDTH-1:0] wr_neuron_q, wr_neuron_d;
    logic [1:0]                 wr_field_q, wr_field_d;
    logic [NEURON_ID_WIDTH-1:0] wr_qaddr_q, wr_qaddr_d;
    logic [FP_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                       err_id_q, err_id_d;
    logic                       err_q_q, err_q_d;

    logic                       loading;
    logic                       beat_ok;
    logic [FP_DATA_WIDTH-1:0]   id_ext;
    logic [FP_DATA_WIDTH-1:0]   q_ext;
    logic                       q_upper_set;

    assign loading     = (state_q == S_HDR) || (state_q == S_QROW);
    assign beat_ok     = in_valid_i && loading;
    assign id_ext      = {{(FP_DATA_WIDTH-NEURON_ID_WIDTH){1'b0}}, neuron_q};
    assign q_ext       = {{(FP_DATA_WIDTH-TEN_DATA_WIDTH){1'b0}}, in_data_i[TEN_DATA_WIDTH-1:0]};
    assign q_upper_set = |in_data_i[FP_DATA_WIDTH-1:TEN_DATA_WIDTH];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            neuron_q    <= '0;
            fld_q       <= '0;
            qaddr_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_neuron_q <= '0;
            wr_field_q  <= '0;
            wr_qaddr_q  <= '0;
            wr_data_q   <= '0;
            err_id_q    <= 1'b0;
            err_q_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            neuron_q    <= neuron_d;
            fld_q       <= fld_d;
            qaddr_q     <= qaddr_d;
            wr_en_q     <= wr_en_d;
            wr_neuron_q <= wr_neuron_d;
            wr_field_q  <= wr_field_d;
            wr_qaddr_q  <= wr_qaddr_d;
            wr_data_q   <= wr_data_d;
            err_id_q    <= err_id_d;
            err_q_q     <= err_q_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        neuron_d    = neuron_q;
        fld_d       = fld_q;
        qaddr_d     = qaddr_q;
        wr_en_d     = 1'b0;
        wr_neuron_d = wr_neuron_q;
        wr_field_d  = wr_field_q;
        wr_qaddr_d  = wr_qaddr_q;
        wr_data_d   = wr_data_q;
        err_id_d    = err_id_q;
        err_q_d     = err_q_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_HDR;
                    neuron_d = '0;
                    fld_d    = '0;
                    qaddr_d  = '0;
                    err_id_d = 1'b0;
                    err_q_d  = 1'b0;
                end
            end
            S_HDR: begin
                if (beat_ok) begin
                    wr_en_d     = 1'b1;
                    wr_neuron_d = neuron_q;
                    wr_field_d  = fld_q;
                    wr_qaddr_d  = '0;
                    wr_data_d   = in_data_i;
                    if (fld_q == FLD_NID) begin
                        if (in_data_i != id_ext) begin
                            err_id_d = 1'b1;
                        end
                        fld_d   = '0;
                        qaddr_d = '0;
                        state_d = S_QROW;
                    end else begin
                        fld_d = fld_q + 2'd1;
                    end
                end
            end
            S_QROW: begin
                if (beat_ok) begin
                    wr_en_d     = 1'b1;
                    wr_neuron_d = neuron_q;
                    wr_field_d  = FLD_Q;
                    wr_qaddr_d  = qaddr_q;
                    // Out-of-range couplings are flagged but the truncated value still lands
                    wr_data_d   = q_ext;
                    if (q_upper_set) begin
                        err_q_d = 1'b1;
                    end
                    // Terminate by compare so non-power-of-2 arrays never rely on wrap
                    if (qaddr_q == LAST_IDX) begin
                        qaddr_d = '0;
                        if (neuron_q == LAST_IDX) begin
                            neuron_d = '0;
                            state_d  = S_DONE;
                        end else begin
                            neuron_d = neuron_q + 1'b1;
                            state_d  = S_HDR;
                        end
                    end else begin
                        qaddr_d = qaddr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready_o  = loading;
    assign busy_o      = loading;
    assign done_o      = (state_q == S_DONE);
    assign wr_en_o     = wr_en_q;
    assign wr_neuron_o = wr_neuron_q;
    assign wr_field_o  = wr_field_q;
    assign wr_qaddr_o  = wr_qaddr_q;
    assign wr_data_o   = wr_data_q;
    assign err_id_o    = err_id_q;
    assign err_q_o     = err_q_q;

endmodule
